// File: rtl/seq_mult_hs.sv
// Multi-cycle unsigned shift-and-add multiplier behind a valid/ready accept
// and a one-cycle done pulse; one operation in flight, fixed latency.
module seq_mult_hs #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic                    valid,
  output logic                    ready,
  output logic [RESULT_WIDTH-1:0] out,
  output logic                    done
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  if (RESULT_WIDTH < 2 * DATA_WIDTH) begin : g_width_check
    $error("seq_mult_hs: RESULT_WIDTH must be >= 2*DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [RESULT_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [RESULT_WIDTH-1:0] acc;
  logic [RESULT_WIDTH-1:0] acc_sum;
  logic [CW-1:0]           count;

  // Partial product for the current iteration, also the final value on the last one
  always_comb begin
    acc_sum = acc;
    if (mplier[0]) acc_sum = acc + mcand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (valid) begin
            mcand  <= RESULT_WIDTH'(a);
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST_ITER) begin
            out   <= acc_sum;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (state == S_IDLE);

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs: directed vectors, corner sequences and
// random traffic against a cycle-level transaction model.
module tb_seq_mult_hs;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          valid;
  logic          ready;
  logic [RW-1:0] out_w;
  logic          done;

  seq_mult_hs #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .valid (valid),
    .ready (ready),
    .out   (out_w),
    .done  (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cycles remaining in the current operation (0 = idle), pending product
  int          busy = 0;
  logic [RW-1:0] pend = '0;
  logic [RW-1:0] last = '0;
  int          accepts = 0;
  int          dones = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check outputs
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      busy = 0;
      last = '0;
    end else if (busy == 0) begin
      if (valid) begin
        busy = DW + 1;
        pend = RW'(a) * RW'(b);
        accepts++;
      end
    end else begin
      busy--;
    end
    @(negedge clk);
    chk("ready", 32'(ready), 32'(busy == 0));
    chk("done", 32'(done), 32'(busy == 1));
    if (busy == 1) begin
      last = pend;
      dones++;
    end
    chk("out", 32'(out_w), 32'(last));
  endtask

  task automatic run_vec(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                         input logic [RW-1:0] exp);
    int n;
    a = va; b = vb; valid = 1'b1;
    step();
    valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("vec_latency", 32'(n), 32'(DW));
    chk("vec_out", 32'(out_w), 32'(exp));
    step();
    chk("vec_ready_back", 32'(ready), 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    int   n;
    int   cyc;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
    vecs[3] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1};
    vecs[4] = '{a: 8'd255, b: 8'd1,   exp: 16'd255};
    vecs[5] = '{a: 8'd128, b: 8'd2,   exp: 16'd256};

    // Reset held with valid asserted: nothing may be accepted
    rst_n = 1'b0; valid = 1'b1; a = 8'hFF; b = 8'hFF;
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out_w), 32'd0);
    repeat (3) step();
    valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i].a, vecs[i].b, vecs[i].exp);

    // Busy-ignore and back-to-back with valid held high
    a = 8'd3; b = 8'd5; valid = 1'b1;
    step();
    a = 8'd7; b = 8'd9;
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    chk("b2b_first_latency", 32'(n), 32'(DW));
    chk("b2b_first_out", 32'(out_w), 32'd15);
    n = 0;
    step(); n++;
    while (!done && n < 30) begin
      chk("b2b_out_hold", 32'(out_w), 32'd15);
      step(); n++;
    end
    chk("b2b_spacing", 32'(n), 32'(DW + 2));
    chk("b2b_second_out", 32'(out_w), 32'd63);
    valid = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of an operation
    a = 8'd100; b = 8'd100; valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    busy = 0; last = '0;
    chk("midrst_out", 32'(out_w), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    step();
    rst_n = 1'b1;
    repeat (DW + 4) step();
    chk("midrst_no_done", 32'(dones), 32'(accepts - 1));
    accepts = dones;
    run_vec(8'd2, 8'd4, 16'd8);

    // Random traffic with random valid gaps and operand churn while busy
    accepts = 0; dones = 0; cyc = 0;
    while (accepts < 1000 && cyc < 40000) begin
      a = DW'($urandom);
      b = DW'($urandom);
      valid = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("rand_accepts", 32'(accepts), 32'd1000);
    valid = 1'b0;
    repeat (DW + 3) step();
    chk("rand_done_count", 32'(dones), 32'(accepts));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
